mem_port_arbiter: RTL and testbench

//  Shares the single-port data SRAM between the IF fetch path (read-only) and the
//  MEM load/store path. Sequences each access through a fixed-latency SRAM cycle,

---
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port data SRAM arbiter between IF fetch (read-only) and MEM load/store, fixed SRAM_LAT latency.
// Optional round-robin arbitration with `define MEM_ARB_RR_EN (default: fixed MEM-over-IF priority).
module mem_port_arbiter #(
   parameter int SRAM_LAT = 2
) (
   input  logic        soc_clk,
   input  logic        MEM_reset,
   input  logic        MEM_stall,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        mem_req,
   input  logic [31:0] mem_addr,
   input  logic        mem_we,
   input  logic [3:0]  mem_be,
   input  logic [31:0] mem_wdata,
   output logic        mem_ack,
   output logic [31:0] mem_rdata,
   output logic        sram_en,
   output logic        sram_we,
   output logic [3:0]  sram_be,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
   output logic        busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic OWN_IF  = 1'b0;
   localparam logic OWN_MEM = 1'b1;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        owner_q, owner_d;
   logic [29:0] waddr_q, waddr_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] cap_q, cap_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;
   logic        grant_mem;
   logic        issue;
   logic        ack_fire;

`ifdef MEM_ARB_RR_EN
   logic        last_owner_q, last_owner_d;

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant_mem = mem_req;
      if (mem_req && if_req) begin
         grant_mem = (last_owner_q == OWN_IF);
      end
   end

   always_comb begin
      last_owner_d = last_owner_q;
      if (state_q == S_IDLE && !MEM_stall && (if_req || mem_req)) begin
         last_owner_d = grant_mem;
      end
   end

   always_ff @(posedge soc_clk or posedge MEM_reset) begin
      if (MEM_reset) begin
         last_owner_q <= OWN_IF;
      end else begin
         last_owner_q <= last_owner_d;
      end
   end
`else
   assign grant_mem = mem_req;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_d     = owner_q;
      waddr_d     = waddr_q;
      we_d        = we_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      cap_d       = cap_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (!MEM_stall && (if_req || mem_req)) begin
               owner_d = grant_mem;
               state_d = S_ISSUE;
               if (grant_mem) begin
                  waddr_d = mem_addr[31:2];
                  we_d    = mem_we;
                  be_d    = mem_be;
                  wdata_d = mem_wdata;
               end else begin
                  waddr_d = if_addr[31:2];
                  we_d    = 1'b0;
                  be_d    = 4'b1111;
                  wdata_d = 32'd0;
               end
            end
         end
         S_ISSUE: begin
            cnt_d   = 4'(SRAM_LAT);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               cap_d   = we_q ? 32'd0 : sram_rdata;
               state_d = S_DONE;
            end
         end
         default: begin
            if (!MEM_stall) begin
               state_d = S_IDLE;
               if (owner_q == OWN_MEM) begin
                  mem_rdata_d = cap_q;
               end else begin
                  if_rdata_d = cap_q;
               end
            end
         end
      endcase
   end

   always_ff @(posedge soc_clk or posedge MEM_reset) begin
      if (MEM_reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         owner_q     <= OWN_IF;
         waddr_q     <= 30'd0;
         we_q        <= 1'b0;
         be_q        <= 4'd0;
         wdata_q     <= 32'd0;
         cap_q       <= 32'd0;
         if_rdata_q  <= 32'd0;
         mem_rdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_q     <= owner_d;
         waddr_q     <= waddr_d;
         we_q        <= we_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         cap_q       <= cap_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   // SRAM fields are only driven during the single ISSUE cycle.
   assign issue      = (state_q == S_ISSUE);
   assign sram_en    = issue;
   assign sram_we    = issue & we_q;
   assign sram_be    = issue ? be_q : 4'd0;
   assign sram_addr  = issue ? {waddr_q, 2'b00} : 32'd0;
   assign sram_wdata = issue ? wdata_q : 32'd0;

   // rdata shows the captured word during the ack cycle and is held afterwards.
   assign ack_fire  = (state_q == S_DONE) && !MEM_stall;
   assign if_ack    = ack_fire && (owner_q == OWN_IF);
   assign mem_ack   = ack_fire && (owner_q == OWN_MEM);
   assign if_rdata  = if_ack  ? cap_q : if_rdata_q;
   assign mem_rdata = mem_ack ? cap_q : mem_rdata_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-cycle vector table plus hand-written reset and arbitration sequences.
module tb_mem_port_arbiter;

   logic        soc_clk = 1'b0;
   logic        clk_run = 1'b0;
   logic        MEM_reset, MEM_stall;
   logic        if_req, mem_req, mem_we;
   logic [31:0] if_addr, mem_addr, mem_wdata, sram_rdata;
   logic [3:0]  mem_be;
   logic        if_ack, mem_ack, sram_en, sram_we, busy;
   logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata;
   logic [3:0]  sram_be;

   mem_port_arbiter #(.SRAM_LAT(2)) dut (
      .soc_clk(soc_clk), .MEM_reset(MEM_reset), .MEM_stall(MEM_stall),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .sram_en(sram_en), .sram_we(sram_we), .sram_be(sram_be), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
   );

   initial forever begin
      #5;
      if (clk_run) soc_clk = ~soc_clk;
   end

   typedef struct {
      logic        stall, ireq, mreq, mwe;
      logic [31:0] iaddr, maddr, mwd, srd;
      logic [3:0]  mbe;
      logic        xen, xwe, xia, xma, xbusy;
      logic [31:0] xaddr, xwd, xird, xmrd;
      logic [3:0]  xbe;
   } row_t;

   row_t        tbl[$];
   logic [31:0] cur_iaddr, cur_maddr, cur_mwd;
   logic        cur_mwe;
   logic [3:0]  cur_mbe;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   function automatic row_t mk(input logic stall, ireq, mreq, input logic [31:0] srd,
                               input logic xen, input logic [31:0] xaddr, input logic xwe,
                               input logic [3:0] xbe, input logic [31:0] xwd,
                               input logic xia, input logic [31:0] xird,
                               input logic xma, input logic [31:0] xmrd, input logic xbusy);
      row_t r;
      r.stall = stall; r.ireq = ireq; r.mreq = mreq; r.srd = srd;
      r.iaddr = cur_iaddr; r.maddr = cur_maddr; r.mwe = cur_mwe; r.mbe = cur_mbe; r.mwd = cur_mwd;
      r.xen = xen; r.xaddr = xaddr; r.xwe = xwe; r.xbe = xbe; r.xwd = xwd;
      r.xia = xia; r.xird = xird; r.xma = xma; r.xmrd = xmrd; r.xbusy = xbusy;
      return r;
   endfunction

   // SRAM fields only matter while sram_en is high; write data only for writes.
   function automatic logic [136:0] pack(input logic en, we, input logic [3:0] be,
                                         input logic [31:0] addr, wd, input logic ia,
                                         input logic [31:0] ird, input logic ma,
                                         input logic [31:0] mrd, input logic bsy);
      return {en, en & we, en ? be : 4'd0, en ? addr : 32'd0, (en & we) ? wd : 32'd0,
              ia, ird, ma, mrd, bsy};
   endfunction

   function automatic logic [136:0] pack_dut();
      return pack(sram_en, sram_we, sram_be, sram_addr, sram_wdata,
                  if_ack, if_rdata, mem_ack, mem_rdata, busy);
   endfunction

   task automatic chk(input string name, input logic [136:0] act, input logic [136:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge soc_clk);
      #1;
   endtask

   initial begin
      logic [31:0] ga[3];
      logic [31:0] ea[3];
      int          got;
      int          k;
      bit          saw_ack;

      MEM_stall = 0; if_req = 0; mem_req = 0; mem_we = 0; mem_be = 0;
      if_addr = 0; mem_addr = 0; mem_wdata = 0; sram_rdata = 0;

      // Reset with the clock stopped.
      MEM_reset = 1'b1;
      #1;
      chk("reset_no_clock", pack_dut(), '0);
      clk_run = 1'b1;
      tick();
      tick();
      MEM_reset = 1'b0;

      // IF read, unaligned address
      cur_iaddr = 32'h13; cur_maddr = 0; cur_mwe = 0; cur_mbe = 0; cur_mwd = 0;
      tbl.push_back(mk(0,1,0,0,            0,0,0,0,0, 0,0,0,0, 0));
      tbl.push_back(mk(0,1,0,0,            1,32'h10,0,4'hF,0, 0,0,0,0, 1));
      tbl.push_back(mk(0,1,0,0,            0,0,0,0,0, 0,0,0,0, 1));
      tbl.push_back(mk(0,1,0,32'hDEADBEEF, 0,0,0,0,0, 0,0,0,0, 1));
      tbl.push_back(mk(0,1,0,0,            0,0,0,0,0, 1,32'hDEADBEEF,0,0, 1));
      tbl.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,32'hDEADBEEF,0,0, 0));
      // Simultaneous requests: MEM read first, IF acked 5 cycles later
      cur_iaddr = 32'h200; cur_maddr = 32'h104; cur_mwe = 0; cur_mbe = 4'hF; cur_mwd = 0;
      tbl.push_back(mk(0,1,1,0,            0,0,0,0,0, 0,32'hDEADBEEF,0,0, 0));
      tbl.push_back(mk(0,1,1,0,            1,32'h104,0,4'hF,0, 0,32'hDEADBEEF,0,0, 1));
      tbl.push_back(mk(0,1,1,0,            0,0,0,0,0, 0,32'hDEADBEEF,0,0, 1));
      tbl.push_back(mk(0,1,1,32'hCAFEF00D, 0,0,0,0,0, 0,32'hDEADBEEF,0,0, 1));
      tbl.push_back(mk(0,1,1,0,            0,0,0,0,0, 0,32'hDEADBEEF,1,32'hCAFEF00D, 1));
      tbl.push_back(mk(0,1,0,0,            0,0,0,0,0, 0,32'hDEADBEEF,0,32'hCAFEF00D, 0));
      tbl.push_back(mk(0,1,0,0,            1,32'h200,0,4'hF,0, 0,32'hDEADBEEF,0,32'hCAFEF00D, 1));
      tbl.push_back(mk(0,1,0,0,            0,0,0,0,0, 0,32'hDEADBEEF,0,32'hCAFEF00D, 1));
      tbl.push_back(mk(0,1,0,32'h0BADF00D, 0,0,0,0,0, 0,32'hDEADBEEF,0,32'hCAFEF00D, 1));
      tbl.push_back(mk(0,1,0,0,            0,0,0,0,0, 1,32'h0BADF00D,0,32'hCAFEF00D, 1));
      tbl.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,32'h0BADF00D,0,32'hCAFEF00D, 0));
      // MEM write, partial byte enables; returned data is 0
      cur_maddr = 32'h23; cur_mwe = 1; cur_mbe = 4'b0011; cur_mwd = 32'h0000A5A5;
      tbl.push_back(mk(0,0,1,0,            0,0,0,0,0, 0,32'h0BADF00D,0,32'hCAFEF00D, 0));
      tbl.push_back(mk(0,0,1,0,            1,32'h20,1,4'b0011,32'hA5A5, 0,32'h0BADF00D,0,32'hCAFEF00D, 1));
      tbl.push_back(mk(0,0,1,0,            0,0,0,0,0, 0,32'h0BADF00D,0,32'hCAFEF00D, 1));
      tbl.push_back(mk(0,0,1,32'h12345678, 0,0,0,0,0, 0,32'h0BADF00D,0,32'hCAFEF00D, 1));
      tbl.push_back(mk(0,0,1,0,            0,0,0,0,0, 0,32'h0BADF00D,1,0, 1));
      tbl.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,32'h0BADF00D,0,0, 0));
      // IF read with stall in cycles 3..6
      cur_iaddr = 32'h300; cur_mwe = 0; cur_mbe = 0; cur_mwd = 0;
      tbl.push_back(mk(0,1,0,0,            0,0,0,0,0, 0,32'h0BADF00D,0,0, 0));
      tbl.push_back(mk(0,1,0,0,            1,32'h300,0,4'hF,0, 0,32'h0BADF00D,0,0, 1));
      tbl.push_back(mk(0,1,0,0,            0,0,0,0,0, 0,32'h0BADF00D,0,0, 1));
      tbl.push_back(mk(1,1,0,32'h55AA55AA, 0,0,0,0,0, 0,32'h0BADF00D,0,0, 1));
      tbl.push_back(mk(1,1,0,0,            0,0,0,0,0, 0,32'h0BADF00D,0,0, 1));
      tbl.push_back(mk(1,1,0,0,            0,0,0,0,0, 0,32'h0BADF00D,0,0, 1));
      tbl.push_back(mk(1,1,0,0,            0,0,0,0,0, 0,32'h0BADF00D,0,0, 1));
      tbl.push_back(mk(0,1,0,0,            0,0,0,0,0, 1,32'h55AA55AA,0,0, 1));
      tbl.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,32'h55AA55AA,0,0, 0));
      // Stall in IDLE blocks the grant
      cur_iaddr = 32'h400;
      tbl.push_back(mk(1,1,0,0,            0,0,0,0,0, 0,32'h55AA55AA,0,0, 0));
      tbl.push_back(mk(1,1,0,0,            0,0,0,0,0, 0,32'h55AA55AA,0,0, 0));
      tbl.push_back(mk(0,1,0,0,            0,0,0,0,0, 0,32'h55AA55AA,0,0, 0));
      tbl.push_back(mk(0,1,0,0,            1,32'h400,0,4'hF,0, 0,32'h55AA55AA,0,0, 1));
      tbl.push_back(mk(0,1,0,0,            0,0,0,0,0, 0,32'h55AA55AA,0,0, 1));
      tbl.push_back(mk(0,1,0,32'h11111111, 0,0,0,0,0, 0,32'h55AA55AA,0,0, 1));
      tbl.push_back(mk(0,1,0,0,            0,0,0,0,0, 1,32'h11111111,0,0, 1));
      tbl.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,32'h11111111,0,0, 0));

      foreach (tbl[i]) begin
         MEM_stall = tbl[i].stall; if_req = tbl[i].ireq; if_addr = tbl[i].iaddr;
         mem_req = tbl[i].mreq; mem_addr = tbl[i].maddr; mem_we = tbl[i].mwe;
         mem_be = tbl[i].mbe; mem_wdata = tbl[i].mwd; sram_rdata = tbl[i].srd;
         #4;
         chk($sformatf("row%0d", i), pack_dut(),
             pack(tbl[i].xen, tbl[i].xwe, tbl[i].xbe, tbl[i].xaddr, tbl[i].xwd,
                  tbl[i].xia, tbl[i].xird, tbl[i].xma, tbl[i].xmrd, tbl[i].xbusy));
         tick();
      end

      // Reset pulsed in WAIT aborts the access
      if_req = 1; if_addr = 32'h700; mem_req = 0; MEM_stall = 0; sram_rdata = 32'h99999999;
      tick();
      tick();
      #2;
      MEM_reset = 1'b1;
      #1;
      chk("reset_in_wait", pack_dut(), '0);
      if_req = 0;
      tick();
      MEM_reset = 1'b0;
      saw_ack = 0;
      for (int c = 0; c < 6; c++) begin
         #4;
         if (if_ack || mem_ack) saw_ack = 1;
         tick();
      end
      chk("no_ack_after_abort", 137'(saw_ack), '0);

      // Fresh IF request after the abort
      if_req = 1; if_addr = 32'h704; sram_rdata = 32'h77777777;
      k = 0;
      #4;
      while (!if_ack && k < 20) begin
         tick();
         k++;
         #4;
      end
      chk("rereq_ack_latency", 137'(k), 137'(4));
      chk("rereq_rdata", 137'(if_rdata), 137'(32'h77777777));
      tick();
      if_req = 0;
      tick();

      // Both requesters held continuously: observe the order of grants
      mem_req = 1; mem_addr = 32'h500; mem_we = 0; mem_be = 4'hF; mem_wdata = 0;
      if_req = 1; if_addr = 32'h600; sram_rdata = 0;
      ga[0] = 0; ga[1] = 0; ga[2] = 0;
`ifdef MEM_ARB_RR_EN
      ea[0] = 32'h500; ea[1] = 32'h600; ea[2] = 32'h500;
`else
      ea[0] = 32'h500; ea[1] = 32'h500; ea[2] = 32'h500;
`endif
      got = 0;
      for (int c = 0; c < 60 && got < 3; c++) begin
         #4;
         if (sram_en) begin
            ga[got] = sram_addr;
            got++;
         end
         tick();
      end
      for (int g = 0; g < 3; g++) chk($sformatf("grant%0d", g), 137'(ga[g]), 137'(ea[g]));
      mem_req = 0; if_req = 0;
      k = 0;
      #4;
      while (busy && k < 30) begin
         tick();
         k++;
         #4;
      end
      chk("drain_idle", 137'(busy), '0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
